// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the posted-write store buffer.
// Ports on the top use the core's own signal names; internal blocks use _i/_o.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int PTR_W    = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } store_entry_t;

    // Entries are kept as flat {addr, data} vectors so that AW/DW overrides still work.
    function automatic logic [SB_AW+SB_DW-1:0] pack_entry(input store_entry_t e);
        return {e.addr, e.data};
    endfunction

endpackage

// File: rtl/sb_entry_ram.sv
// Entry storage for the store buffer: register array, one synchronous write port
// and one asynchronous read port. Contents are deliberately never reset.
module sb_entry_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core store port and a valid/ready write port.
// First-word fall-through; outputs depend only on registered state, never on MemWrite.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic                     m_valid,
    output logic [AW-1:0]            m_addr,
    output logic [DW-1:0]            m_data,
    input  logic                     m_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          push, pop, drop;
    logic [EW-1:0] head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign m_valid = ~empty;
    assign count   = count_q;
    assign overflow = overflow_q;

    // Head is forced to zero when empty so stale entries never leak onto the port.
    assign m_addr = empty ? '0 : head[EW-1:DW];
    assign m_data = empty ? '0 : head[DW-1:0];

    always_comb begin
        pop  = m_valid & m_ready;
        // A full buffer still accepts a store if the head leaves in the same cycle.
        push = MemWrite & (~full | pop);
        drop = MemWrite & full & ~pop;

        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    sb_entry_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .PW    (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push & reset),
        .waddr_i (wr_ptr_q),
        .wdata_i ({DataAdr, WriteData}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single store, fill/overflow,
// full push+pop, wrap-around streaming and reset mid-operation.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_ready;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int fa [4] = '{96, 100, 104, 108};
    int fd [4] = '{7, 25, 3, 9};

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd25;
        m_ready   = 1'b0;

        // Reset held with a store strobe active
        step();
        step();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_data", m_data, 0);

        // Single store, held under back-pressure, then drained
        reset = 1'b1;
        step();
        MemWrite = 1'b0;
        chk("one_valid", 32'(m_valid), 1);
        chk("one_addr", m_addr, 100);
        chk("one_data", m_data, 25);
        chk("one_count", 32'(count), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_addr", m_addr, 100);
            chk("hold_data", m_data, 25);
            chk("hold_valid", 32'(m_valid), 1);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("one_empty", 32'(empty), 1);
        chk("one_zaddr", m_addr, 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(fa[i]); WriteData = 32'(fd[i]);
            step();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_ovf0", 32'(overflow), 0);
        DataAdr = 32'd112; WriteData = 32'd55;
        step();
        MemWrite = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_head", m_addr, 96);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", m_addr, 32'(fa[i]));
            chk("drain_data", m_data, 32'(fd[i]));
            step();
        end
        m_ready = 1'b0;
        chk("drain_empty", 32'(empty), 1);
        chk("drain_valid", 32'(m_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset clears the sticky flag; then full with push+pop together
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst2_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(fa[i]); WriteData = 32'(fd[i]);
            step();
        end
        chk("pp_count0", 32'(count), 4);
        DataAdr = 32'd200; WriteData = 32'd1; m_ready = 1'b1;
        step();
        MemWrite = 1'b0;
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_count", 32'(count), 4);
        begin
            int pa [4] = '{100, 104, 108, 200};
            int pd [4] = '{25, 3, 9, 1};
            for (int i = 0; i < 4; i++) begin
                chk("pp_addr", m_addr, 32'(pa[i]));
                chk("pp_data", m_data, 32'(pd[i]));
                step();
            end
        end
        chk("pp_empty", 32'(empty), 1);

        // Wrap-around streaming with m_ready held high
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            MemWrite = 1'b1; DataAdr = 32'(4 * k); WriteData = 32'(k);
            step();
            chk("wrap_valid", 32'(m_valid), 1);
            chk("wrap_addr", m_addr, 32'(4 * k));
            chk("wrap_data", m_data, 32'(k));
            chk("wrap_count", 32'(count), 1);
        end
        MemWrite = 1'b0;
        step();
        m_ready = 1'b0;
        chk("wrap_empty", 32'(empty), 1);

        // Reset with entries queued discards them
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(300 + 4 * i); WriteData = 32'(40 + i);
            step();
        end
        MemWrite = 1'b0;
        chk("mid_count3", 32'(count), 3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_count", 32'(count), 0);
        chk("mid_valid", 32'(m_valid), 0);
        chk("mid_ovf", 32'(overflow), 0);
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd25;
        step();
        MemWrite = 1'b0;
        chk("mid_addr", m_addr, 100);
        chk("mid_data", m_data, 25);
        chk("mid_count1", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
